ides10_align_ctrl: RTL and testbench

// Word-alignment controller for one IDES10 1:10 deserializer lane. Generates the divide-by-5 PCLK

---
 rtl/ides10_align_ctrl_if.sv | 24 ++
 rtl/ides10_align_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_ides10_align_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ides10_align_ctrl_if.sv
// Signal bundle between one IDES10 lane's word-alignment controller and the lane top.
// The controller uses the slave view; the lane top (or a bench) uses the master view.
interface ides10_align_ctrl_if;
  logic       enable_i;
  logic [9:0] q_i;
  logic       pclk_o;
  logic       word_stb_o;
  logic       ides_rst_o;
  logic       calib_o;
  logic       locked_o;
  logic       fail_o;
  logic [3:0] slip_cnt_o;
  logic [2:0] state_o;

  modport master (
    output enable_i, q_i,
    input  pclk_o, word_stb_o, ides_rst_o, calib_o, locked_o, fail_o, slip_cnt_o, state_o
  );

  modport slave (
    input  enable_i, q_i,
    output pclk_o, word_stb_o, ides_rst_o, calib_o, locked_o, fail_o, slip_cnt_o, state_o
  );
endinterface

// File: rtl/ides10_align_ctrl.sv
// Word-alignment controller for one IDES10 1:10 lane: makes the divide-by-5 PCLK and word strobe,
// bitslips with CALIB until the training word is stable, reports lock and re-trains on error bursts.
module ides10_align_ctrl #(
  parameter logic [9:0] PATTERN   = 10'h3E0,
  parameter int         SETTLE    = 4,
  parameter int         MATCH_CNT = 16,
  parameter int         MAX_SLIP  = 10,
  parameter int         CALIB_LEN = 5,
  parameter int         ERR_LIMIT = 4
) (
  input  logic               fclk_i,
  input  logic               rst,
  ides10_align_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_IRST   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_SLIP   = 3'd4;
  localparam logic [2:0] ST_LOCKED = 3'd5;
  localparam logic [2:0] ST_FAIL   = 3'd6;

  localparam int IRST_WORDS = 2;
  localparam int WCNT_MAX   = (SETTLE > IRST_WORDS) ? SETTLE : IRST_WORDS;
  localparam int WCNT_W     = $clog2(WCNT_MAX + 1);
  localparam int MATCH_W    = $clog2(MATCH_CNT + 1);
  localparam int ERR_W      = $clog2(ERR_LIMIT + 1);
  localparam int CAL_W      = $clog2(CALIB_LEN + 1);

  localparam logic [WCNT_W-1:0]  IRST_LAST   = WCNT_W'(IRST_WORDS - 1);
  localparam logic [WCNT_W-1:0]  SETTLE_LAST = WCNT_W'(SETTLE - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(MATCH_CNT - 1);
  localparam logic [ERR_W-1:0]   ERR_LAST    = ERR_W'(ERR_LIMIT - 1);
  localparam logic [CAL_W-1:0]   CAL_LAST    = CAL_W'(CALIB_LEN - 1);
  localparam logic [3:0]         SLIP_LIMIT  = 4'(MAX_SLIP);

  // ---------------------------------------------------------------------------
  // PCLK divider and word strobe
  // ---------------------------------------------------------------------------
  logic [2:0] cnt_q, cnt_d;
  logic       word_stb_q;
  logic       clk_b_q;

  assign cnt_d = (cnt_q == 3'd4) ? 3'd0 : cnt_q + 3'd1;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge fclk_i) begin
    if (!rst) begin
      cnt_q      <= 3'd0;
      word_stb_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      word_stb_q <= (cnt_d == 3'd0);
    end
  end

  // Half-cycle copy of cnt[1] stretches the PCLK high phase to 2.5 fclk cycles.
  always_ff @(negedge fclk_i) begin
    if (!rst) clk_b_q <= 1'b0;
    else      clk_b_q <= cnt_q[1];
  end

  assign bus.pclk_o     = cnt_q[1] | clk_b_q;
  assign bus.word_stb_o = word_stb_q;

  // ---------------------------------------------------------------------------
  // Alignment FSM
  // ---------------------------------------------------------------------------
  logic [2:0]         state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [CAL_W-1:0]   cal_q, cal_d;
  logic [3:0]         slip_q, slip_d;
  logic               word;
  logic               q_match;

  assign word    = word_stb_q;
  assign q_match = (bus.q_i == PATTERN);

  // NOTE: every variable gets a default at the top of the always_comb so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    match_d = match_q;
    err_d   = err_q;
    cal_d   = cal_q;
    slip_d  = slip_q;

    if (!bus.enable_i) begin
      // Abort immediately, mid-pulse included; slip count survives until the next IDES reset.
      state_d = ST_IDLE;
      wcnt_d  = '0;
      match_d = '0;
      err_d   = '0;
      cal_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IRST;
          wcnt_d  = '0;
          slip_d  = 4'd0;
        end

        ST_IRST: begin
          if (word) begin
            if (wcnt_q == IRST_LAST) begin
              state_d = ST_SETTLE;
              wcnt_d  = '0;
            end else begin
              wcnt_d = wcnt_q + WCNT_W'(1);
            end
          end
        end

        ST_SETTLE: begin
          if (word) begin
            if (wcnt_q == SETTLE_LAST) begin
              state_d = ST_CHECK;
              wcnt_d  = '0;
              match_d = '0;
            end else begin
              wcnt_d = wcnt_q + WCNT_W'(1);
            end
          end
        end

        ST_CHECK: begin
          if (word) begin
            if (q_match) begin
              match_d = match_q + MATCH_W'(1);
              if (match_q == MATCH_LAST) begin
                state_d = ST_LOCKED;
                err_d   = '0;
              end
            end else if (slip_q < SLIP_LIMIT) begin
              state_d = ST_SLIP;
              cal_d   = '0;
              slip_d  = (slip_q == 4'hF) ? slip_q : slip_q + 4'd1;
            end else begin
              state_d = ST_FAIL;
            end
          end
        end

        ST_SLIP: begin
          // Counts raw fclk cycles, not words: CALIB is one PCLK period wide.
          if (cal_q == CAL_LAST) begin
            state_d = ST_SETTLE;
            wcnt_d  = '0;
            cal_d   = '0;
          end else begin
            cal_d = cal_q + CAL_W'(1);
          end
        end

        ST_LOCKED: begin
          if (word) begin
            if (q_match) begin
              err_d = '0;
            end else if (err_q == ERR_LAST) begin
              state_d = ST_IRST;
              wcnt_d  = '0;
              err_d   = '0;
              slip_d  = 4'd0;
            end else begin
              err_d = err_q + ERR_W'(1);
            end
          end
        end

        ST_FAIL: begin
          state_d = ST_FAIL;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same edge as state_o
  // and never glitch while the state bits settle.
  logic ides_rst_q, calib_q, locked_q, fail_q;

  always_ff @(posedge fclk_i) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      match_q    <= '0;
      err_q      <= '0;
      cal_q      <= '0;
      slip_q     <= 4'd0;
      ides_rst_q <= 1'b1;
      calib_q    <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      match_q    <= match_d;
      err_q      <= err_d;
      cal_q      <= cal_d;
      slip_q     <= slip_d;
      ides_rst_q <= (state_d == ST_IDLE) || (state_d == ST_IRST);
      calib_q    <= (state_d == ST_SLIP);
      locked_q   <= (state_d == ST_LOCKED);
      fail_q     <= (state_d == ST_FAIL);
    end
  end

  assign bus.ides_rst_o = ides_rst_q;
  assign bus.calib_o    = calib_q;
  assign bus.locked_o   = locked_q;
  assign bus.fail_o     = fail_q;
  assign bus.slip_cnt_o = slip_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_ides10_align_ctrl.sv
// Directed bench for ides10_align_ctrl: IDES10 model rotates a PATTERN stream on every CALIB pulse.
module tb_ides10_align_ctrl;
  localparam logic [9:0] PATTERN = 10'h3E0;

  logic fclk = 1'b0;
  logic rst;

  ides10_align_ctrl_if bus();

  ides10_align_ctrl dut (
    .fclk_i (fclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 fclk = ~fclk;

  // IDES10 model: word rotation = rot_base + CALIB pulses seen so far.
  int  rot_base   = 0;
  bit  const_mode = 1'b0;
  bit  bad_word   = 1'b0;
  int  pulses     = 0;
  int  wrong_w    = 0;
  int  cur_w      = 0;
  logic calib_prev = 1'b0;

  function automatic logic [9:0] rotl(input logic [9:0] v, input int k);
    logic [9:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  assign bus.q_i = bad_word   ? 10'h000 :
                   const_mode ? 10'h155 :
                   rotl(PATTERN, (rot_base + pulses) % 10);

  always @(negedge fclk) begin
    if (bus.calib_o === 1'b1) begin
      if (calib_prev !== 1'b1) begin
        pulses = pulses + 1;
        cur_w  = 1;
      end else begin
        cur_w = cur_w + 1;
      end
    end else if (calib_prev === 1'b1) begin
      if (cur_w != 5) wrong_w = wrong_w + 1;
    end
    calib_prev = bus.calib_o;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic next_word(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge fclk);
      if (bus.word_stb_o === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      if (bus.state_o === st) got = 1'b1;
    end
    check(name, got, 1);
  endtask

  task automatic set_rotation(input int desired);
    rot_base = (desired + 10 - (pulses % 10)) % 10;
  endtask

  typedef struct {
    bit         bad;
    logic       exp_locked;
    logic [2:0] exp_state;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;
    int highs, rises, stb_cnt, stb_gap_err, last_stb, idle_bad, words, p0, w0;
    logic prev_p, pclk_s;
    bit got;

    vecs[0] = '{1'b1, 1'b1, 3'd5};
    vecs[1] = '{1'b1, 1'b1, 3'd5};
    vecs[2] = '{1'b1, 1'b1, 3'd5};
    vecs[3] = '{1'b0, 1'b1, 3'd5};
    vecs[4] = '{1'b1, 1'b1, 3'd5};
    vecs[5] = '{1'b1, 1'b1, 3'd5};
    vecs[6] = '{1'b1, 1'b1, 3'd5};
    vecs[7] = '{1'b1, 1'b0, 3'd1};

    // 1: reset values, then free-running divider with enable low
    rst = 1'b0;
    bus.enable_i = 1'b0;
    repeat (4) @(posedge fclk);
    @(negedge fclk);
    #1;
    check("rst_pclk", bus.pclk_o, 0);
    check("rst_stb", bus.word_stb_o, 0);
    check("rst_ides_rst", bus.ides_rst_o, 1);
    check("rst_calib", bus.calib_o, 0);
    check("rst_locked", bus.locked_o, 0);
    check("rst_fail", bus.fail_o, 0);
    check("rst_slip", bus.slip_cnt_o, 0);
    check("rst_state", bus.state_o, 0);
    rst = 1'b1;

    highs = 0; rises = 0; stb_cnt = 0; stb_gap_err = 0; last_stb = -1; idle_bad = 0;
    prev_p = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pclk_s = bus.pclk_o;
      if (pclk_s === 1'b1) highs++;
      if (pclk_s === 1'b1 && prev_p === 1'b0) rises++;
      prev_p = pclk_s;
      if (bus.word_stb_o === 1'b1) begin
        stb_cnt++;
        if (last_stb >= 0 && i - last_stb != 5) stb_gap_err++;
        last_stb = i;
      end
      if (bus.ides_rst_o !== 1'b1 || bus.calib_o !== 1'b0 || bus.locked_o !== 1'b0 ||
          bus.fail_o !== 1'b0 || bus.state_o !== 3'd0) idle_bad++;
      @(negedge fclk);
      #1;
      pclk_s = bus.pclk_o;
      if (pclk_s === 1'b1) highs++;
      if (pclk_s === 1'b1 && prev_p === 1'b0) rises++;
      prev_p = pclk_s;
    end
    check("div_high_halves", highs, 20);
    check("div_rises", rises, 4);
    check("stb_count", stb_cnt, 4);
    check("stb_spacing", stb_gap_err, 0);
    check("idle_outputs", idle_bad, 0);

    // 2: aligned stream locks after 22 words with no slips
    set_rotation(0);
    p0 = pulses;
    next_word(ok);
    tick();
    bus.enable_i = 1'b1;
    words = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      next_word(ok);
      tick();
      words++;
      if (bus.locked_o === 1'b1) got = 1'b1;
    end
    check("aligned_lock_words", words, 22);
    check("aligned_slip_cnt", bus.slip_cnt_o, 0);
    check("aligned_no_calib", pulses - p0, 0);
    check("aligned_ides_rst", bus.ides_rst_o, 0);

    // 3: stream offset by 3 bits -> three 5-cycle CALIB pulses
    bus.enable_i = 1'b0;
    tick();
    check("disable_idle", bus.state_o, 0);
    set_rotation(7);
    p0 = pulses; w0 = wrong_w;
    bus.enable_i = 1'b1;
    wait_state(3'd5, 2000, "offset_lock_reached");
    check("offset_pulses", pulses - p0, 3);
    check("offset_pulse_width", wrong_w - w0, 0);
    check("offset_slip_cnt", bus.slip_cnt_o, 3);
    check("offset_locked", bus.locked_o, 1);

    // 4: never-matching input -> 10 slips then FAIL, cleared by enable low
    bus.enable_i = 1'b0;
    tick();
    const_mode = 1'b1;
    p0 = pulses;
    bus.enable_i = 1'b1;
    wait_state(3'd6, 5000, "fail_reached");
    check("fail_pulses", pulses - p0, 10);
    check("fail_flag", bus.fail_o, 1);
    check("fail_not_locked", bus.locked_o, 0);
    check("fail_slip_cnt", bus.slip_cnt_o, 10);
    check("fail_ides_rst", bus.ides_rst_o, 0);
    repeat (10) tick();
    check("fail_held", bus.state_o, 6);
    bus.enable_i = 1'b0;
    tick();
    check("fail_exit_state", bus.state_o, 0);
    check("fail_exit_flag", bus.fail_o, 0);

    // 5: error tolerance in LOCKED, table driven
    const_mode = 1'b0;
    set_rotation(0);
    bus.enable_i = 1'b1;
    wait_state(3'd5, 2000, "relock_reached");
    foreach (vecs[k]) begin
      next_word(ok);
      bad_word = vecs[k].bad;
      tick();
      check($sformatf("lockvec%0d_locked", k), bus.locked_o, vecs[k].exp_locked);
      check($sformatf("lockvec%0d_state", k), bus.state_o, vecs[k].exp_state);
    end
    bad_word = 1'b0;
    check("retrain_ides_rst", bus.ides_rst_o, 1);
    wait_state(3'd5, 2000, "retrain_relock");
    check("retrain_locked", bus.locked_o, 1);

    // 6: enable dropped in the 2nd cycle of a CALIB pulse
    bus.enable_i = 1'b0;
    tick();
    set_rotation(9);
    bus.enable_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (bus.calib_o === 1'b1) got = 1'b1;
    end
    check("abort_calib_seen", got, 1);
    tick();
    check("abort_calib_2nd", bus.calib_o, 1);
    bus.enable_i = 1'b0;
    tick();
    check("abort_calib_off", bus.calib_o, 0);
    check("abort_state", bus.state_o, 0);
    check("abort_slip_kept", bus.slip_cnt_o, 1);
    bus.enable_i = 1'b1;
    tick();
    check("abort_irst", bus.state_o, 1);
    check("abort_slip_clear", bus.slip_cnt_o, 0);

    // Mid-operation reset returns everything, divider phase included
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("midrst_state", bus.state_o, 0);
    check("midrst_ides_rst", bus.ides_rst_o, 1);
    check("midrst_stb", bus.word_stb_o, 0);
    @(negedge fclk);
    #1;
    check("midrst_pclk", bus.pclk_o, 0);
    rst = 1'b1;
    bus.enable_i = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
